// File: rtl/phase_slot_sched_pkg.sv
// Shared definitions for the clk2x phase-slot scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phase_slot_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } lock_st_e;

    // res_sel encoding: which requester the resource data came from
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int LOCK_CNT_DEF = 8;
    localparam int ERR_MAX_DEF  = 2;

endpackage

// File: rtl/phase_slot_sched_lock_fsm.sv
// Qualifies the clk1x phase indication: IDLE -> HUNT -> LOCKED lock tracker.
// Latency: good/locked_st are same-cycle decodes; locked/lockerr are registered (1 cycle).
// Backpressure: none; en=0 forces IDLE on the next edge without a lockerr pulse.
module phase_lock_fsm
    import phase_slot_sched_pkg::*;
#(
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_MAX  = ERR_MAX_DEF
) (
    input  logic clk2x,
    input  logic rst2x_,
    input  logic phasein,
    input  logic en,
    output logic good,
    output logic locked_st,
    output logic locked,
    output logic lockerr
);

    localparam logic [7:0] LOCK_CNT_M1 = 8'(LOCK_CNT - 1);
    localparam logic [3:0] ERR_MAX_M1  = 4'(ERR_MAX - 1);

    lock_st_e   state_q, state_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic       ph_q;
    logic       lockerr_q, lockerr_d;
    logic       locked_q, locked_d;

    // A healthy detector toggles every clk2x cycle, so a repeat is a bad cycle
    assign good      = (phasein != ph_q);
    assign locked_st = (state_q == ST_LOCKED);
    assign locked    = locked_q;
    assign lockerr   = lockerr_q;

    // Next-state and counter update; en=0 overrides everything
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        err_cnt_d  = err_cnt_q;
        lockerr_d  = 1'b0;
        if (!en) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_HUNT;
                    lock_cnt_d = '0;
                end
                ST_HUNT: begin
                    if (good) begin
                        if (lock_cnt_q == LOCK_CNT_M1) begin
                            state_d   = ST_LOCKED;
                            err_cnt_d = '0;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 8'd1;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (good) begin
                        err_cnt_d = '0;
                    end else if (err_cnt_q == ERR_MAX_M1) begin
                        state_d    = ST_HUNT;
                        lockerr_d  = 1'b1;
                        lock_cnt_d = '0;
                        err_cnt_d  = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // State, counters, phase history and registered status outputs
    always_ff @(posedge clk2x or negedge rst2x_) begin
        if (!rst2x_) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            err_cnt_q  <= '0;
            ph_q       <= 1'b0;
            lockerr_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            err_cnt_q  <= err_cnt_d;
            ph_q       <= phasein;
            lockerr_q  <= lockerr_d;
            locked_q   <= locked_d;
        end
    end

endmodule

// File: rtl/phase_slot_sched.sv
// Fixed TDM of clk1x requesters A (phase-1 slots) and B (phase-0 slots) onto one clk2x port.
// Latency: 1 clk2x cycle from a qualifying request to gnt/res_vld; res_sel/res_dat hold when idle.
// Backpressure: none; grants are withheld while unlocked, disabled or on bad phase cycles. Option macro PHASE_SLOT_STAT_EN adds stats.
module phase_slot_sched
    import phase_slot_sched_pkg::*;
#(
    parameter int DW       = 32,
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int ERR_MAX  = ERR_MAX_DEF
) (
    input  logic          clk2x,
    input  logic          rst2x_,
    input  logic          phasein,
    input  logic          en,
    input  logic          req_a,
    input  logic [DW-1:0] dat_a,
    input  logic          req_b,
    input  logic [DW-1:0] dat_b,
`ifdef PHASE_SLOT_STAT_EN
    input  logic          clr_stat,
    output logic [7:0]    errcnt,
    output logic [7:0]    slipcnt,
`endif
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          res_vld,
    output logic          res_sel,
    output logic [DW-1:0] res_dat,
    output logic          locked,
    output logic          lockerr
);

    logic          good;
    logic          locked_st;
    logic          slot_ok;
    logic          take_a;
    logic          take_b;
    logic          gnt_a_q, gnt_a_d;
    logic          gnt_b_q, gnt_b_d;
    logic          res_vld_q, res_vld_d;
    logic          res_sel_q, res_sel_d;
    logic [DW-1:0] res_dat_q, res_dat_d;

    phase_lock_fsm #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_MAX  (ERR_MAX)
    ) u_lock (
        .clk2x     (clk2x),
        .rst2x_    (rst2x_),
        .phasein   (phasein),
        .en        (en),
        .good      (good),
        .locked_st (locked_st),
        .locked    (locked),
        .lockerr   (lockerr)
    );

    // en is included so the edge that drops to IDLE registers no grant
    assign slot_ok = locked_st && good && en;
    assign take_a  = slot_ok && phasein && req_a;
    assign take_b  = slot_ok && !phasein && req_b;

    // Slot mux: phase picks the owner; an unused slot is never lent out
    always_comb begin
        gnt_a_d   = take_a;
        gnt_b_d   = take_b;
        res_vld_d = take_a || take_b;
        res_sel_d = res_sel_q;
        res_dat_d = res_dat_q;
        if (take_a) begin
            res_sel_d = SEL_A;
            res_dat_d = dat_a;
        end else if (take_b) begin
            res_sel_d = SEL_B;
            res_dat_d = dat_b;
        end
    end

    // Grant and resource-port registers
    always_ff @(posedge clk2x or negedge rst2x_) begin
        if (!rst2x_) begin
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            res_vld_q <= 1'b0;
            res_sel_q <= 1'b0;
            res_dat_q <= '0;
        end else begin
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            res_vld_q <= res_vld_d;
            res_sel_q <= res_sel_d;
            res_dat_q <= res_dat_d;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign res_vld = res_vld_q;
    assign res_sel = res_sel_q;
    assign res_dat = res_dat_q;

`ifdef PHASE_SLOT_STAT_EN
    logic [7:0] errcnt_q, errcnt_d;
    logic [7:0] slipcnt_q, slipcnt_d;

    // Saturating health counters; a clear beats a same-cycle increment
    always_comb begin
        errcnt_d  = errcnt_q;
        slipcnt_d = slipcnt_q;
        if (clr_stat) begin
            errcnt_d  = '0;
            slipcnt_d = '0;
        end else begin
            if (locked_st && !good && errcnt_q != 8'hFF) begin
                errcnt_d = errcnt_q + 8'd1;
            end
            if (lockerr && slipcnt_q != 8'hFF) begin
                slipcnt_d = slipcnt_q + 8'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk2x or negedge rst2x_) begin
        if (!rst2x_) begin
            errcnt_q  <= '0;
            slipcnt_q <= '0;
        end else begin
            errcnt_q  <= errcnt_d;
            slipcnt_q <= slipcnt_d;
        end
    end

    assign errcnt  = errcnt_q;
    assign slipcnt = slipcnt_q;
`endif

endmodule

// File: tb/tb_phase_slot_sched.sv
// Scoreboard bench for phase_slot_sched: driver pushes predicted outputs, monitor pops and compares.
// Inputs change on the falling edge; outputs sampled 1 time unit after the rising edge.
// The reference model tracks trust in the phase stream as run lengths of good/bad cycles.
module tb_phase_slot_sched;

    localparam int DW = 32;
    localparam int LC = 8;
    localparam int EM = 2;

    localparam int MODE_OFF     = 0;
    localparam int MODE_SEARCH  = 1;
    localparam int MODE_TRUSTED = 2;

    logic          clk2x;
    logic          rst2x_;
    logic          phasein;
    logic          en;
    logic          req_a;
    logic [DW-1:0] dat_a;
    logic          req_b;
    logic [DW-1:0] dat_b;
    logic          gnt_a;
    logic          gnt_b;
    logic          res_vld;
    logic          res_sel;
    logic [DW-1:0] res_dat;
    logic          locked;
    logic          lockerr;
`ifdef PHASE_SLOT_STAT_EN
    logic          clr_stat;
    logic [7:0]    errcnt;
    logic [7:0]    slipcnt;
`endif

    phase_slot_sched #(.DW(DW), .LOCK_CNT(LC), .ERR_MAX(EM)) dut (
        .clk2x   (clk2x),
        .rst2x_  (rst2x_),
        .phasein (phasein),
        .en      (en),
        .req_a   (req_a),
        .dat_a   (dat_a),
        .req_b   (req_b),
        .dat_b   (dat_b),
`ifdef PHASE_SLOT_STAT_EN
        .clr_stat(clr_stat),
        .errcnt  (errcnt),
        .slipcnt (slipcnt),
`endif
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .res_vld (res_vld),
        .res_sel (res_sel),
        .res_dat (res_dat),
        .locked  (locked),
        .lockerr (lockerr)
    );

    initial clk2x = 1'b0;
    always #5 clk2x = ~clk2x;

    typedef struct {
        logic          lk;
        logic          le;
        logic          vld;
        logic          ga;
        logic          gb;
        logic          sel;
        logic [DW-1:0] dat;
        logic [7:0]    ec;
        logic [7:0]    sc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model state
    int          m_mode;
    int          good_run;
    int          bad_run;
    logic        prev_ph;
    logic        m_sel;
    logic [DW-1:0] m_dat;
    int          m_ec;
    int          m_sc;
    logic        m_le;
    logic        ph_cur;

    task automatic model_reset();
        m_mode   = MODE_OFF;
        good_run = 0;
        bad_run  = 0;
        prev_ph  = 1'b0;
        m_sel    = 1'b0;
        m_dat    = '0;
        m_ec     = 0;
        m_sc     = 0;
        m_le     = 1'b0;
    endtask

    // Apply one cycle of inputs and predict the outputs after the next rising edge
    task automatic step(input logic e, input logic hold, input logic ra, input logic rb,
                        input logic [DW-1:0] da, input logic [DW-1:0] db, input logic clr);
        exp_t x;
        logic good;
        logic grant;
        logic le;
        @(negedge clk2x);
        if (!hold) ph_cur = ~ph_cur;
        en      = e;
        phasein = ph_cur;
        req_a   = ra;
        req_b   = rb;
        dat_a   = da;
        dat_b   = db;
`ifdef PHASE_SLOT_STAT_EN
        clr_stat = clr;
`endif
        good  = (ph_cur != prev_ph);
        grant = (m_mode == MODE_TRUSTED) && e && good && (ph_cur ? ra : rb);
        x.ga  = grant && ph_cur;
        x.gb  = grant && !ph_cur;
        x.vld = grant;
        if (grant) begin
            m_sel = ph_cur ? 1'b0 : 1'b1;
            m_dat = ph_cur ? da : db;
        end
        x.sel = m_sel;
        x.dat = m_dat;
        if (clr) begin
            m_ec = 0;
            m_sc = 0;
        end else begin
            if (m_mode == MODE_TRUSTED && !good && m_ec < 255) m_ec++;
            if (m_le && m_sc < 255) m_sc++;
        end
        x.ec = 8'(m_ec);
        x.sc = 8'(m_sc);
        le = 1'b0;
        if (!e) begin
            m_mode   = MODE_OFF;
            good_run = 0;
            bad_run  = 0;
        end else if (m_mode == MODE_OFF) begin
            m_mode   = MODE_SEARCH;
            good_run = 0;
        end else if (m_mode == MODE_SEARCH) begin
            if (good) begin
                good_run++;
                if (good_run == LC) begin
                    m_mode  = MODE_TRUSTED;
                    bad_run = 0;
                end
            end else begin
                good_run = 0;
            end
        end else begin
            if (good) begin
                bad_run = 0;
            end else begin
                bad_run++;
                if (bad_run == EM) begin
                    m_mode   = MODE_SEARCH;
                    good_run = 0;
                    bad_run  = 0;
                    le       = 1'b1;
                end
            end
        end
        m_le    = le;
        x.le    = le;
        x.lk    = (m_mode == MODE_TRUSTED);
        prev_ph = ph_cur;
        exp_q.push_back(x);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({gnt_a, gnt_b, res_vld, res_sel, locked, lockerr} != 6'b0 || res_dat != '0) begin
            fails++;
            $display("FAIL %s: got ga=%0b gb=%0b vld=%0b sel=%0b dat=%h lk=%0b le=%0b, expected all zero",
                     name, gnt_a, gnt_b, res_vld, res_sel, res_dat, locked, lockerr);
        end
    endtask

    // Monitor: compare every presented cycle against the oldest prediction
    always begin
        exp_t x;
        logic bad;
        @(posedge clk2x);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            tests++;
            bad = (locked !== x.lk) || (lockerr !== x.le) || (res_vld !== x.vld) ||
                  (gnt_a !== x.ga) || (gnt_b !== x.gb) || (res_sel !== x.sel) || (res_dat !== x.dat);
`ifdef PHASE_SLOT_STAT_EN
            bad = bad || (errcnt !== x.ec) || (slipcnt !== x.sc);
`endif
            if (bad) begin
                fails++;
                $display("FAIL cycle_%0d: got lk=%0b le=%0b vld=%0b ga=%0b gb=%0b sel=%0b dat=%h, expected lk=%0b le=%0b vld=%0b ga=%0b gb=%0b sel=%0b dat=%h ec=%0d sc=%0d",
                         cyc, locked, lockerr, res_vld, gnt_a, gnt_b, res_sel, res_dat,
                         x.lk, x.le, x.vld, x.ga, x.gb, x.sel, x.dat, x.ec, x.sc);
            end
            tests++;
            if (gnt_a && gnt_b) begin
                fails++;
                $display("FAIL gnt_exclusive cycle_%0d: got ga=1 gb=1, expected at most one", cyc);
            end
        end
    end

    initial begin
        logic ra;
        logic rb;
        rst2x_  = 1'b0;
        phasein = 1'b0;
        en      = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        dat_a   = '0;
        dat_b   = '0;
`ifdef PHASE_SLOT_STAT_EN
        clr_stat = 1'b0;
`endif
        ph_cur = 1'b0;
        model_reset();
        repeat (2) @(posedge clk2x);
        #3 rst2x_ = 1'b1;
        check_zero("reset_state");

        // Enable after two idle cycles, then hunt and lock with random requests
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 14; i++)
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);

        // Both requesters busy with fixed data
        repeat (12) step(1'b1, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0);

        // A idle: its slots stay empty
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0);

        // Single glitch keeps lock, double glitch loses it and relocks
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 32'h4444_4444, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'h6666_6666, 1'b0);
        repeat (14) step(1'b1, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b0);

        // Disable while granting, then re-enable
        step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b0);
        repeat (14) step(1'b1, 1'b0, 1'b1, 1'b1, $urandom, $urandom, 1'b0);

        // Asynchronous reset mid-operation
        @(posedge clk2x);
        #3 rst2x_ = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk2x);
        #3 rst2x_ = 1'b1;
        model_reset();

        // Randomized traffic with occasional phase slips, disables and stat clears
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (i % 2 == 0) begin
                ra = 1'($urandom_range(0, 3) != 0);
                rb = 1'($urandom_range(0, 3) != 0);
            end
            step(1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 9) == 0), ra, rb,
                 $urandom, $urandom, 1'($urandom_range(0, 29) == 0));
        end

        repeat (3) @(posedge clk2x);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d predictions left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase_slot_sched.md
Name: phase_slot_sched

Overview:
- clk2x-domain time-slot scheduler for a shared resource that runs at twice the clk1x rate.
- Consumes the 1-bit clk1x phase indication from the phase detector and qualifies it with a lock FSM.
- Time-multiplexes two clk1x-paced requesters, A and B, onto one clk2x resource port: A owns phase-1 cycles and B owns phase-0 cycles.
- Blocks all grants while phase alignment is not trusted.

Parameters:
- DW, 32, data width of requester and resource data.
- LOCK_CNT, 8, consecutive good phase alternations needed to declare lock (legal range 2..255).
- ERR_MAX, 2, consecutive bad phase cycles in LOCKED that force loss of lock (legal range 1..15).

Ports:
- clk2x  in  1  2x clock; the block's only clock.
- rst2x_  in  1  asynchronous active-low reset.
- phasein  in  1  phase indication from the detector; expected to toggle every clk2x cycle.
- en  in  1  scheduler enable; level, synchronous.
- req_a  in  1  requester A valid; held stable for a full clk1x period.
- dat_a  in  DW  requester A data.
- req_b  in  1  requester B valid.
- dat_b  in  DW  requester B data.
- gnt_a  out  1  one-cycle grant to A.
- gnt_b  out  1  one-cycle grant to B.
- res_vld  out  1  resource port valid.
- res_sel  out  1  source of res_dat: 0 = A, 1 = B.
- res_dat  out  DW  resource port data.
- locked  out  1  FSM is in LOCKED.
- lockerr  out  1  one-cycle pulse on loss of lock.

Behaviour:
- Clock and reset: one clock, clk2x; reset rst2x_ is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; ph_q = 0; all counters 0.
- Reset is honoured mid-transfer; any in-flight grant is dropped.
- ph_q is phasein registered every cycle. good = (phasein != ph_q); bad = !good.
- States: IDLE, HUNT, LOCKED.
  - IDLE: goes to HUNT when en=1; lock counter cleared.
  - HUNT: on good, lock counter increments; on bad, it clears to 0. When the counter reaches LOCK_CNT-1 on a good cycle, go to LOCKED and clear the error counter.
  - LOCKED: on bad, the error counter increments; on good, it clears. When a bad cycle arrives with the error counter at ERR_MAX-1, go to HUNT, pulse lockerr for one cycle, and clear the lock counter.
  - en=0 in any state: go to IDLE on the next edge; no lockerr pulse.
- Grant, evaluated combinationally on the current cycle's state and inputs and registered to the outputs (1-cycle latency):
  - State must be LOCKED and the cycle must be good.
  - phasein=1 and req_a: next cycle gnt_a=1, res_vld=1, res_sel=0, res_dat=dat_a.
  - phasein=0 and req_b: next cycle gnt_b=1, res_vld=1, res_sel=1, res_dat=dat_b.
  - Otherwise res_vld=0, gnt_a=gnt_b=0, and res_dat/res_sel hold their last value.
- Fixed TDM: an idle A slot is never given to B, and vice versa.
- gnt_a and gnt_b are never high together; at most one grant per requester per clk1x period.
- A bad cycle in LOCKED suppresses the grant for that cycle, even if lock is retained.
- The cycle that enters LOCKED issues no grant; grants start from the following cycle.
- Leaving LOCKED (to HUNT or IDLE): no grant registered from that edge onward; locked falls the same edge.
- locked is the registered decode of state == LOCKED.

Optional Feature:
- Macro PHASE_SLOT_STAT_EN. When defined, the block adds:
  - input clr_stat (1 bit, synchronous);
  - output errcnt (8 bits): saturating count (stops at 255) of bad cycles seen in LOCKED;
  - output slipcnt (8 bits): saturating count of lockerr pulses.
- clr_stat zeroes both counters. If clr_stat coincides with an increment event, the clear wins.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, HUNT=2'd1, LOCKED=2'd2;
  - res_sel constants: SEL_A=1'b0, SEL_B=1'b1;
  - default LOCK_CNT and ERR_MAX.
- One natural sub-module: phase_lock_fsm. It takes phasein, en and the parameters and produces locked_st, good and lockerr. The top level keeps the slot mux, grant registers and the optional stats.

Test Plan:
- Reset and enable: drive phasein toggling, en=1 from cycle 2 -> HUNT at cycle 3, locked=1 after 8 good cycles; all outputs 0 before that.
- Grants: locked, req_a=req_b=1 held, dat_a=32'hA5A5_0001, dat_b=32'h5A5A_0002 -> alternating res_vld cycles with res_sel 0/1 and matching data; gnt_a and gnt_b never coincide.
- Idle slot: locked, req_a=0, req_b=1 -> res_vld only on phase-0 cycles; no A-slot reuse.
- Single glitch (ERR_MAX=2): hold phasein for one extra cycle -> that cycle grantless, locked stays 1, grants resume next good cycle.
- Double glitch: hold phasein for 2 extra cycles -> lockerr pulse, locked=0, HUNT, relock after 8 good cycles.
- Mid-operation cases:
  - en=0 while granting -> IDLE next edge, no lockerr.
  - assert rst2x_ low asynchronously -> all outputs 0 immediately.
  - with PHASE_SLOT_STAT_EN: errcnt=3 after three bad cycles; clr_stat zeroes it.
